// File: rtl/snes_multi_controller.sv
// snes_multi_controller
//   Polls NUM_PADS SNES controllers in parallel over a shared data_clk /
//   data_latch pair, one serial line per pad. Frames start either from the
//   free-running poll tick (AUTO_POLL=1) or from i_poll_now. Each completed
//   frame publishes the per-pad button words and presence flags together
//   with a one-cycle o_sample_valid strobe.
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous, active-high reset
//   i_serial_in     per-pad serial data, active-low pressed
//   i_poll_now      request an immediate frame (ignored while busy)
//   o_data_clk      shared controller clock (idles high)
//   o_data_latch    shared controller latch
//   o_busy          high for the whole frame (LATCH and DATA)
//   o_button_state  pad p at [12p+11:12p], B,Y,SEL,START,U,D,L,R,A,X,L,R; active high
//   o_connected     per-pad presence from the last completed frame
//   o_sample_valid  one-cycle strobe when button_state/connected update
//   o_pressed_edge  (only with SNES_PRESS_EDGE_EN) new & ~old buttons,
//                   valid in the o_sample_valid cycle, 0 otherwise
//
// Optional feature macro: SNES_PRESS_EDGE_EN
module snes_multi_controller #(
  parameter int CLK_HZ    = 100000000,
  parameter int POLL_HZ   = 60,
  parameter int BIT_US    = 12,
  parameter int NUM_PADS  = 2,
  parameter int NUM_BITS  = 16,
  parameter int AUTO_POLL = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_PADS-1:0]      i_serial_in,
  input  logic                     i_poll_now,
  output logic                     o_data_clk,
  output logic                     o_data_latch,
  output logic                     o_busy,
  output logic [NUM_PADS*12-1:0]   o_button_state,
  output logic [NUM_PADS-1:0]      o_connected,
`ifdef SNES_PRESS_EDGE_EN
  output logic [NUM_PADS*12-1:0]   o_pressed_edge,
`endif
  output logic                     o_sample_valid
);

  localparam int BIT_CYC  = CLK_HZ / 1000000 * BIT_US;
  localparam int HALF     = BIT_CYC / 2;
  localparam int POLL_CYC = CLK_HZ / POLL_HZ;
  localparam int BW       = $clog2(BIT_CYC);
  localparam int PW       = $clog2(POLL_CYC);
  localparam int IW       = $clog2(NUM_BITS);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0] SAMPLE_AT = BW'(HALF - 1);
  localparam logic [BW-1:0] HALF_CNT  = BW'(HALF);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BITS - 1);
  localparam logic [IW-1:0] IDX_BTN   = IW'(12);

  typedef enum logic [1:0] {S_WAIT, S_LATCH, S_DATA} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_poll_cnt;
  logic [BW-1:0]   r_bit_cnt;
  logic [IW-1:0]   r_bit_idx;
  logic            r_sample_valid;

  logic w_tick;
  logic w_req;
  logic w_bit_end;
  logic w_sample;
  logic w_frame_start;
  logic w_frame_end;

  assign w_tick        = (r_poll_cnt == POLL_LAST);
  // A tick and a poll_now in the same cycle collapse into one request.
  assign w_req         = ((AUTO_POLL != 0) && w_tick) || i_poll_now;
  assign w_bit_end     = (r_bit_cnt == BIT_LAST);
  assign w_sample      = (r_state == S_DATA) && (r_bit_cnt == SAMPLE_AT);
  assign w_frame_start = (r_state == S_WAIT) && w_req;
  // The last bit period runs to completion so every bit gets a full
  // data_clk low half; results are published at its end.
  assign w_frame_end   = (r_state == S_DATA) && w_bit_end && (r_bit_idx == IDX_LAST);

  // Free-running poll timebase, independent of frame activity.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_poll_cnt <= '0;
    end else if (w_tick) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_data_clk   = 1'b1;
    o_data_latch = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_req) w_state_next = S_LATCH;
      end
      S_LATCH: begin
        o_data_latch = 1'b1;
        o_busy       = 1'b1;
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        o_busy     = 1'b1;
        o_data_clk = (r_bit_cnt < HALF_CNT);
        if (w_frame_end) w_state_next = S_WAIT;
      end
      default: w_state_next = S_WAIT;
    endcase
  end

  // Bit-period counter and bit index; both held at zero in WAIT so a new
  // frame always starts from a clean count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else if (r_state == S_WAIT) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else if (w_bit_end) begin
      r_bit_cnt <= '0;
      if (r_state == S_DATA) r_bit_idx <= r_bit_idx + 1'b1;
    end else begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= w_frame_end;
    end
  end

  assign o_sample_valid = r_sample_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [11:0] r_shadow;
      logic        r_absent;
      logic [11:0] r_buttons;
      logic        r_conn;
      logic [11:0] w_new;

      assign w_new = r_absent ? 12'h000 : r_shadow;

      // Right shift with the inverted sample entering at the top: after
      // twelve samples bit k holds the k-th button.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_shadow <= '0;
          r_absent <= 1'b0;
        end else if (w_frame_start) begin
          r_shadow <= '0;
          r_absent <= 1'b0;
        end else if (w_sample) begin
          if (r_bit_idx < IDX_BTN) begin
            r_shadow <= {~i_serial_in[gi], r_shadow[11:1]};
          end else if (!i_serial_in[gi]) begin
            r_absent <= 1'b1;
          end
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_buttons <= '0;
          r_conn    <= 1'b0;
        end else if (w_frame_end) begin
          r_buttons <= w_new;
          r_conn    <= ~r_absent;
        end
      end

      assign o_button_state[gi*12 +: 12] = r_buttons;
      assign o_connected[gi]             = r_conn;

`ifdef SNES_PRESS_EDGE_EN
      logic [11:0] r_edge;

      // A disconnected pad publishes zero buttons, so its edges vanish too.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_edge <= '0;
        end else if (w_frame_end) begin
          r_edge <= w_new & ~r_buttons;
        end else begin
          r_edge <= '0;
        end
      end

      assign o_pressed_edge[gi*12 +: 12] = r_edge;
`endif
    end
  endgenerate

endmodule
